// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural LO/HI registers.
// Optional MULDIV_EARLY_EXIT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             killE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             divzero,
  output logic [1:0]       dbg_state
);

  // Handshake: startE is taken in IDLE or DONE (killE wins); busy stays high until
  // LO/HI are written, and done pulses for the single cycle after the write.
  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               op_div;
  logic               res_neg;
  logic               rem_neg;
  logic               zero_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;

  logic               launch;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] mul_next;
  logic [CW-1:0]      ee_shift;
  logic               mul_early;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_step;
  logic               last;
  logic               calc_exit;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH-1:0]   fix_hi;

  assign launch   = startE && !killE && (state == S_IDLE || state == S_DONE);
  assign a_mag_in = (opE[0] && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign b_mag_in = (opE[0] && srcbE[WIDTH-1]) ? -srcbE : srcbE;

  // Shift-add: the carry out of the upper-half add becomes the new MSB after the shift.
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a_mag};
  assign mul_step = b_mag[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
  assign ee_shift = CW'(WIDTH - 1) - count;
  assign mul_early = EARLY_EXIT && !op_div && (b_mag[WIDTH-1:1] == '0);
  assign mul_next = mul_early ? (mul_step >> ee_shift) : mul_step;

  // Partial remainder needs one extra bit once shifted left.
  assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_mag};
  assign div_diff  = div_shift - {1'b0, b_mag};
  assign div_step  = div_ge ? {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};

  assign last      = (count == CW'(WIDTH - 1));
  assign calc_exit = last || mul_early;

  assign mul_res = res_neg ? -prod : prod;
  assign quo     = prod[WIDTH-1:0];
  assign rem     = prod[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_lo = mul_res[WIDTH-1:0];
    fix_hi = mul_res[2*WIDTH-1:WIDTH];
    if (op_div) begin
      if (zero_div) begin
        fix_lo = '1;
        fix_hi = a_raw;
      end else begin
        fix_lo = res_neg ? -quo : quo;
        fix_hi = rem_neg ? -rem : rem;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (launch) begin
          if (srcbE == '0 && (opE[1] || EARLY_EXIT)) state_next = S_FIX;
          else                                         state_next = S_CALC;
        end
      end
      S_CALC:  if (calc_exit) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (killE) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      zero_div <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      a_raw    <= '0;
      prod     <= '0;
      count    <= '0;
      lo       <= '0;
      hi       <= '0;
      divzero  <= 1'b0;
    end else if (launch) begin
      op_div   <= opE[1];
      res_neg  <= opE[0] && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
      rem_neg  <= opE[0] && opE[1] && srcaE[WIDTH-1];
      zero_div <= opE[1] && (srcbE == '0);
      a_mag    <= a_mag_in;
      b_mag    <= b_mag_in;
      a_raw    <= srcaE;
      prod     <= opE[1] ? {{WIDTH{1'b0}}, a_mag_in} : '0;
      count    <= '0;
      divzero  <= 1'b0;
    end else if (!killE && state == S_CALC) begin
      prod  <= op_div ? div_step : mul_next;
      count <= count + 1'b1;
      if (!op_div) b_mag <= b_mag >> 1;
    end else if (!killE && state == S_FIX) begin
      lo      <= fix_lo;
      hi      <= fix_hi;
      divzero <= zero_div;
    end
  end

  assign busy      = (state == S_CALC) || (state == S_FIX);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the execute stage. It replaces the combinational lo/hi path of the ALU.
- Accepts MULT/MULTU/DIV/DIVU operands from the forwarded execute sources and runs one radix-2 step per cycle.
- Holds the architectural LO/HI registers, which feed the memory-stage mflo/mfhi muxes.
- Asserts busy so the hazard unit stalls F/D/E while a result is outstanding.

Parameters:
- WIDTH, 32, operand and LO/HI width; count width is clog2(WIDTH)+1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- startE  input  1  launch operation (muldivE from control)
- opE  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- srcaE  input  WIDTH  rs operand (multiplicand / dividend)
- srcbE  input  WIDTH  rt operand (multiplier / divisor)
- killE  input  1  abort in-flight operation (exception/flush)
- busy  output  1  operation in progress; stall request to hazard unit
- done  output  1  one-cycle pulse: lo/hi just updated
- lo  output  WIDTH  LO register
- hi  output  WIDTH  HI register
- divzero  output  1  sticky flag: last division had divisor 0; cleared by next start

Behaviour:
- Reset (reset=0, async): state IDLE; lo=0, hi=0, busy=0, done=0, divzero=0; internal accumulators and count cleared.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - On startE=1, latch the operand magnitudes. For signed ops use the absolute value; 0x80000000 stays 0x80000000 as unsigned magnitude.
  - Latch the result sign (a^b for MULT/DIV) and the remainder sign (sign of a, DIV only).
  - Set count=0 and go to CALC. busy=1 from the next cycle.
- CALC, multiply:
  - Shift-add on a 2*WIDTH product register.
  - Per cycle: if multiplier LSB=1, add the multiplicand to the upper half; then shift right 1.
- CALC, divide:
  - Restoring division on a {remainder, quotient} register.
  - Per cycle: shift left 1, trial-subtract the divisor from the remainder.
  - If the result is non-negative, keep it and set quotient bit 0 to 1.
- CALC exit: count increments each cycle; after WIDTH iterations (count==WIDTH-1 on the last step) go to FIX.
- FIX:
  - Apply sign correction: negate the 64-bit product for MULT with negative sign; negate the quotient / remainder independently for DIV.
  - Write lo/hi on this edge: multiply gives hi=product[63:32], lo=product[31:0]; divide gives lo=quotient, hi=remainder.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, busy=0. Go to IDLE. A startE in DONE is accepted as if in IDLE, enabling back-to-back operations.
- Latency: start sampled at edge 0; lo/hi update at edge WIDTH+1 (edge 33); done high the cycle after. busy is high for cycles 1..WIDTH+1.
- startE while in CALC or FIX: ignored; operands are not relatched.
- Divide by zero: skip CALC, FIX writes lo=all-ones, hi=dividend (unsigned original a), divzero=1. Latency is then 2 cycles to done.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0. No trap.
- killE=1 in any state: return to IDLE next edge, lo/hi unchanged, done=0. killE has priority over startE in the same cycle.
- lo/hi change only in FIX. They are stable otherwise, so mflo/mfhi reads during busy see old values; the hazard unit stalls them via busy.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: in multiply CALC, if the remaining unshifted multiplier bits are all zero, finish the remaining shifts in one cycle and go directly to FIX, right-aligning the product. Latency becomes (index of highest set multiplier bit + 1) + 2 cycles; multiplier 0 gives 2 cycles. Divide is unaffected.
- Undefined: fixed WIDTH+2 latency for all non-zero-divisor ops.

Test Plan:
- Reset mid-CALC (reset low at cycle 10 of a MULTU) -> lo=hi=0, busy=0 immediately (async); no done pulse after release.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then a back-to-back DIV 0xFFFFFFF9 / 2 started in the DONE cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> done at cycle 2, lo=0xFFFFFFFF, hi=100, divzero=1. A following DIVU 100 / 7 -> lo=14, hi=2, divzero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Then a killE pulse at cycle 5 of a new MULTU -> busy drops next cycle, lo/hi keep 0x80000000/0, no done.
- With MULDIV_EARLY_EXIT_EN: MULTU 1234 x 5 -> lo=6170, hi=0, done at cycle 5. Without the macro: same result, done at cycle 34.
